// File: rtl/instr_fetch_buffer.sv
// Instruction fetch queue: issues one read per cycle, result visible on inst two cycles after imem_en.
// Stalls the PC unit when queued plus in-flight entries fill the queue; redirect or reset flushes everything.
module instr_fetch_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [CW-1:0]         occ;
    logic                  flush, push, pop;

    // Occupancy counts the in-flight read so a returning word always has a free slot.
    assign occ        = count_q + CW'(pend_q);
    assign stall      = !rst && (occ >= CW'(DEPTH));
    assign imem_en    = !stall && !redirect && !rst;
    assign imem_addr  = pc;
    assign inst_valid = !rst && (count_q != '0);
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = addr_q[rd_ptr_q];

    assign flush = rst || redirect;
    assign push  = pend_q && !flush;
    assign pop   = inst_valid && inst_ready && !flush;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pend_d    = imem_en;
        pend_pc_d = imem_en ? pc : pend_pc_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            addr_q[wr_ptr_q] <= pend_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) !(push && count_q == CW'(DEPTH)));

endmodule
